// File: rtl/otter_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package otter_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_FMT      = 2'd3
  } err_code_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic signed [31:0] IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IS_MAX = 32'sd2047;
  localparam logic signed [31:0] B_MIN  = -32'sd4096;
  localparam logic signed [31:0] B_MAX  = 32'sd4094;
  localparam logic signed [31:0] J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] J_MAX  = 32'sd1048574;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters the immediate into the format's bit slots
// and checks it; any error substitutes the canonical NOP.
module imm_pack
  import otter_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic [1:0]  err_code_o
);

  logic [31:0]        raw;
  err_code_e          code;
  logic signed [31:0] simm;

  assign simm = signed'(imm_i);

  always_comb begin
    raw  = 32'h0;
    code = ERR_NONE;
    case (fmt_e'(fmt_i))
      FMT_R: raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        if (!in_range(simm, IS_MIN, IS_MAX)) code = ERR_RANGE;
      end
      FMT_S: begin
        raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        if (!in_range(simm, IS_MIN, IS_MAX)) code = ERR_RANGE;
      end
      FMT_B: begin
        raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
               imm_i[4:1], imm_i[11], opcode_i};
        // Alignment outranks range, so test it first.
        if (imm_i[0])                            code = ERR_MISALIGN;
        else if (!in_range(simm, B_MIN, B_MAX))  code = ERR_RANGE;
      end
      FMT_U: begin
        raw = {imm_i[31:12], rd_i, opcode_i};
        if (imm_i[11:0] != 12'h0) code = ERR_RANGE;
      end
      FMT_J: begin
        raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        if (imm_i[0])                            code = ERR_MISALIGN;
        else if (!in_range(simm, J_MIN, J_MAX))  code = ERR_RANGE;
      end
      default: code = ERR_FMT;
    endcase
  end

  assign instr_o    = (code == ERR_NONE) ? raw : NOP;
  assign err_code_o = code;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one-deep output register with valid/ready,
// sequential word address and saturating word/error counters.
module instr_encoder
  import otter_enc_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IE_clr,
  input  logic             IE_in_valid,
  output logic             IE_in_ready,
  input  logic [2:0]       IE_fmt,
  input  logic [6:0]       IE_opcode,
  input  logic [4:0]       IE_rd,
  input  logic [4:0]       IE_rs1,
  input  logic [4:0]       IE_rs2,
  input  logic [2:0]       IE_funct3,
  input  logic [6:0]       IE_funct7,
  input  logic [31:0]      IE_imm,
  output logic             IE_out_valid,
  input  logic             IE_out_ready,
  output logic [31:0]      IE_instr,
  output logic [31:0]      IE_addr,
  output logic             IE_err,
  output logic [1:0]       IE_err_code,
  output logic [CNT_W-1:0] IE_word_cnt,
  output logic [CNT_W-1:0] IE_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      pk_instr;
  logic [1:0]       pk_code;

  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  logic in_hs, out_hs;

  imm_pack u_pack (
    .fmt_i      (IE_fmt),
    .opcode_i   (IE_opcode),
    .rd_i       (IE_rd),
    .rs1_i      (IE_rs1),
    .rs2_i      (IE_rs2),
    .funct3_i   (IE_funct3),
    .funct7_i   (IE_funct7),
    .imm_i      (IE_imm),
    .instr_o    (pk_instr),
    .err_code_o (pk_code)
  );

  assign IE_in_ready = !valid_q || IE_out_ready;
  assign in_hs       = IE_in_valid && IE_in_ready;
  assign out_hs      = valid_q && IE_out_ready;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    err_d   = err_q;
    code_d  = code_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    ecnt_d  = ecnt_q;

    // Payload only moves on accept, so a stalled word holds by construction.
    if (in_hs) begin
      valid_d = 1'b1;
      instr_d = pk_instr;
      err_d   = (pk_code != ERR_NONE);
      code_d  = pk_code;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end

    // Clear touches only the bookkeeping, never the held word.
    if (IE_clr) begin
      addr_d = ADDR_BASE;
      wcnt_d = '0;
      ecnt_d = '0;
    end else if (out_hs) begin
      addr_d = addr_q + 32'd4;
      if (wcnt_q != CNT_MAX)          wcnt_d = wcnt_q + CNT_ONE;
      if (err_q && ecnt_q != CNT_MAX) ecnt_d = ecnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      addr_q  <= ADDR_BASE;
      wcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign IE_out_valid = valid_q;
  assign IE_instr     = instr_q;
  assign IE_err       = err_q;
  assign IE_err_code  = code_q;
  assign IE_addr      = addr_q;
  assign IE_word_cnt  = wcnt_q;
  assign IE_err_cnt   = ecnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: table stream, backpressure, clear,
// counter saturation/address wrap, round trip through an immediate decoder.
module tb_instr_encoder;

  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] S_BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr, addr;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] word_cnt, err_cnt;

  // Second instance: narrow counters and a base near the top of memory.
  logic        s_valid = 1'b0;
  logic        s_in_ready, s_out_valid, s_err;
  logic [31:0] s_instr, s_addr;
  logic [1:0]  s_code;
  logic [3:0]  s_wcnt, s_ecnt;
  logic        s_clr = 1'b0;
  logic        s_out_ready = 1'b1;
  logic [2:0]  s_fmt = 3'd7;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_BASE(BASE), .CNT_W(16)) dut (
    .CLK(clk), .RST_N(rst_n), .IE_clr(clr),
    .IE_in_valid(in_valid), .IE_in_ready(in_ready),
    .IE_fmt(fmt), .IE_opcode(opcode), .IE_rd(rd), .IE_rs1(rs1), .IE_rs2(rs2),
    .IE_funct3(funct3), .IE_funct7(funct7), .IE_imm(imm),
    .IE_out_valid(out_valid), .IE_out_ready(out_ready),
    .IE_instr(instr), .IE_addr(addr), .IE_err(err), .IE_err_code(err_code),
    .IE_word_cnt(word_cnt), .IE_err_cnt(err_cnt)
  );

  instr_encoder #(.ADDR_BASE(S_BASE), .CNT_W(4)) dut_sat (
    .CLK(clk), .RST_N(rst_n), .IE_clr(s_clr),
    .IE_in_valid(s_valid), .IE_in_ready(s_in_ready),
    .IE_fmt(s_fmt), .IE_opcode(7'h33), .IE_rd(5'd1), .IE_rs1(5'd2), .IE_rs2(5'd3),
    .IE_funct3(3'd0), .IE_funct7(7'd0), .IE_imm(32'd0),
    .IE_out_valid(s_out_valid), .IE_out_ready(s_out_ready),
    .IE_instr(s_instr), .IE_addr(s_addr), .IE_err(s_err), .IE_err_code(s_code),
    .IE_word_cnt(s_wcnt), .IE_err_cnt(s_ecnt)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] im,
                     input logic [31:0] e, input logic [1:0] c);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.f3 = f3; v.f7 = f7; v.imm = im; v.exp = e; v.code = c;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm; in_valid = 1'b1;
  endtask

  task automatic drive_i(input logic [4:0] d, input logic [31:0] im);
    fmt = 3'd1; opcode = 7'h13; rd = d; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = im; in_valid = 1'b1;
  endtask

  function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] i);
    case (f)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {i[31:12], 12'h000};
      default: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    int          n_words, n_errs;

    // fmt  op     rd  rs1 rs2 f3  f7     imm             expected       code
    add(3'd1, 7'h13, 1, 0, 0, 0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
    add(3'd3, 7'h63, 0, 0, 0, 0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'd0);
    add(3'd5, 7'h6F, 1, 0, 0, 0, 7'h00, 32'h0000_0008, 32'h0080_00EF, 2'd0);
    add(3'd4, 7'h37, 5, 0, 0, 0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    add(3'd0, 7'h33, 3, 1, 2, 0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 2'd0);
    add(3'd2, 7'h23, 0, 1, 2, 2, 7'h00, 32'h0000_0008, 32'h0020_A423, 2'd0);
    add(3'd2, 7'h23, 0, 1, 2, 2, 7'h00, 32'hFFFF_FFFC, 32'hFE20_AE23, 2'd0);
    add(3'd1, 7'h13, 1, 0, 0, 0, 7'h00, 32'h0000_07FF, 32'h7FF0_0093, 2'd0);
    add(3'd1, 7'h13, 1, 0, 0, 0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 2'd0);
    add(3'd3, 7'h63, 0, 0, 0, 0, 7'h00, 32'h0000_0FFE, 32'h7E00_0FE3, 2'd0);
    add(3'd3, 7'h63, 0, 0, 0, 0, 7'h00, 32'hFFFF_F000, 32'h8000_0063, 2'd0);
    add(3'd5, 7'h6F, 1, 0, 0, 0, 7'h00, 32'hFFF0_0000, 32'h8000_00EF, 2'd0);
    add(3'd4, 7'h37, 0, 0, 0, 0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F037, 2'd0);
    add(3'd1, 7'h13, 1, 0, 0, 0, 7'h00, 32'h0000_0800, 32'h0000_0013, 2'd1);
    add(3'd3, 7'h63, 0, 0, 0, 0, 7'h00, 32'h0000_0005, 32'h0000_0013, 2'd2);
    add(3'd6, 7'h13, 1, 0, 0, 0, 7'h00, 32'h0000_0000, 32'h0000_0013, 2'd3);
    add(3'd2, 7'h23, 0, 1, 2, 2, 7'h00, 32'hFFFF_F7FF, 32'h0000_0013, 2'd1);
    add(3'd3, 7'h63, 0, 0, 0, 0, 7'h00, 32'h0000_1001, 32'h0000_0013, 2'd2);
    add(3'd5, 7'h6F, 1, 0, 0, 0, 7'h00, 32'h0010_0000, 32'h0000_0013, 2'd1);
    add(3'd4, 7'h37, 1, 0, 0, 0, 7'h00, 32'h1234_5001, 32'h0000_0013, 2'd1);
    add(3'd7, 7'h13, 1, 0, 0, 0, 7'h00, 32'h0000_0003, 32'h0000_0013, 2'd3);
    add(3'd5, 7'h6F, 1, 0, 0, 0, 7'h00, 32'h0000_0003, 32'h0000_0013, 2'd2);

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {29'd0, err, err_code}, 32'd0);
    chk("rst_addr", addr, BASE);
    chk("rst_cnts", {word_cnt, err_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Table stream at full throughput
    n_words = 0; n_errs = 0; exp_addr = BASE;
    @(negedge clk); drive(vecs[0]);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_instr", k), instr, vecs[k].exp);
      chk($sformatf("v%0d_code", k), {29'd0, err, err_code},
          {29'd0, vecs[k].code != 2'd0, vecs[k].code});
      chk($sformatf("v%0d_addr", k), addr, exp_addr);
      chk($sformatf("v%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
      exp_addr += 32'd4; n_words++;
      if (vecs[k].code != 2'd0) n_errs++;
      if (k + 1 < vecs.size()) drive(vecs[k+1]);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("word_cnt", {16'd0, word_cnt}, n_words);
    chk("err_cnt", {16'd0, err_cnt}, n_errs);
    chk("addr_after", addr, exp_addr);

    // Backpressure: A accepted, B waits while A is held three cycles
    out_ready = 1'b0;
    drive_i(5'd1, 32'd1);
    chk("bp_ready_a", {31'd0, in_ready}, 32'd1);
    @(negedge clk); drive_i(5'd2, 32'd2);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_hold%0d_instr", c), instr, 32'h0010_0093);
      chk($sformatf("bp_hold%0d_addr", c), addr, exp_addr);
      chk($sformatf("bp_hold%0d_ready", c), {30'd0, in_ready, out_valid}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_instr", instr, 32'h0020_0113);
    chk("bp_b_addr", addr, exp_addr + 32'd4);
    drive_i(5'd3, 32'd3);
    @(negedge clk);
    chk("bp_c_instr", instr, 32'h0030_0193);
    chk("bp_c_addr", addr, exp_addr + 32'd8);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain", {31'd0, out_valid}, 32'd0);
    chk("bp_word_cnt", {16'd0, word_cnt}, n_words + 3);

    // Clear coincident with a handshake, then clear while holding
    drive_i(5'd2, 32'd1);
    @(negedge clk); drive_i(5'd3, 32'd2); clr = 1'b1;
    @(negedge clk); clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("clr_addr", addr, BASE);
    chk("clr_cnts", {word_cnt, err_cnt}, 32'd0);
    chk("clr_held", instr, 32'h0020_0193);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("clr_hold_instr", instr, 32'h0020_0193);
    out_ready = 1'b1;
    @(negedge clk);
    chk("clr_after_cnt", {16'd0, word_cnt}, 32'd1);
    chk("clr_after_addr", addr, BASE + 32'd4);

    // Round trip through the core's immediate decode
    for (int f = 1; f <= 5; f++) begin
      for (int r = 0; r < 8; r++) begin
        logic [31:0] ri;
        case (f)
          1, 2:    ri = 32'($urandom_range(0, 4095)) - 32'd2048;
          3:       ri = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
          4:       ri = $urandom & 32'hFFFF_F000;
          default: ri = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
        endcase
        fmt = 3'(f); opcode = 7'h13; rd = 5'd7; rs1 = 5'd9; rs2 = 5'd11;
        funct3 = 3'd0; funct7 = 7'd0; imm = ri; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("rt_f%0d_%0d", f, r), {err, dec_imm(3'(f), instr)}, {1'b0, ri});
      end
    end
    @(negedge clk);

    // Narrow-counter instance: 29 illegal-format words, counters pin at 15
    s_valid = 1'b1;
    repeat (30) @(negedge clk);
    chk("sat_word_cnt", {28'd0, s_wcnt}, 32'd15);
    chk("sat_err_cnt", {28'd0, s_ecnt}, 32'd15);
    chk("sat_addr_wrap", s_addr, 32'h0000_006C);
    chk("sat_word", {s_instr[31:2], s_code}, {30'h0000_0004, 2'd3});
    s_valid = 1'b0;

    // Reset while a word is held drops it
    out_ready = 1'b0;
    drive_i(5'd4, 32'd5);
    @(negedge clk); in_valid = 1'b0;
    chk("mid_held", instr, 32'h0050_0213);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {30'd0, out_valid, in_ready}, 32'd1);
    chk("mid_rst_state", {instr[31:0]}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V RV32I instruction encoder: the inverse of the core's immediate generator. Accepts decoded fields plus a full 32-bit signed immediate over a valid/ready handshake, range- and alignment-checks the immediate for the selected format, and packs it into a 32-bit instruction word. Output words carry a sequential instruction-memory address, feeding the boot/program loader that writes the OTTER instruction memory.

## Interface
Parameters:
- ADDR_BASE, 32'h0000_0000, address tagged on the first word after reset or clear
- CNT_W, 16, width of the word and error counters

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IE_clr  in  1  synchronous clear of address and counters
- IE_in_valid  in  1  request valid
- IE_in_ready  out  1  encoder can accept
- IE_fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 illegal
- IE_opcode  in  7  opcode field
- IE_rd, IE_rs1, IE_rs2  in  5 each  register fields
- IE_funct3  in  3; IE_funct7  in  7
- IE_imm  in  32  signed byte-offset or value; U format takes the full upper value
- IE_out_valid  out  1  word valid
- IE_out_ready  in  1  consumer accepts
- IE_instr  out  32  encoded word
- IE_addr  out  32  address of IE_instr
- IE_err  out  1  word replaced by NOP
- IE_err_code  out  2  0 none, 1 range, 2 misaligned, 3 bad format
- IE_word_cnt, IE_err_cnt  out  CNT_W  saturating counters

## Operation
- Packing, with opcode in [6:0]:
  - R: funct7|rs2|rs1|funct3|rd
  - I: imm[11:0]|rs1|funct3|rd
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]
  - U: imm[31:12]|rd
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd
- Checks, in priority order: bad fmt (3) > misaligned (2) > range (1).
  - I/S: imm in [-2048, 2047].
  - B: imm[0]=0; imm in [-4096, 4094].
  - J: imm[0]=0; imm in [-2^20, 2^20-2].
  - U: imm[11:0]=0, otherwise range error.
  - R: imm ignored, never errors.
- On error: IE_instr = 32'h0000_0013 (addi x0,x0,0), IE_err=1, IE_err_code set. The word is still emitted so the address stream stays aligned.
- Address:
  - IE_addr holds the current word's address.
  - Advances by 4 on each output handshake (IE_out_valid & IE_out_ready).
  - Wraps modulo 2^32.
- Counters:
  - IE_word_cnt increments per output handshake.
  - IE_err_cnt increments per handshake with IE_err=1.
  - Both saturate at all-ones.
- IE_clr:
  - Sets address to ADDR_BASE and both counters to 0.
  - Has priority over a same-cycle handshake increment.
  - Does not flush the output register.

## Timing
- Single output register stage: latency is 1 cycle from input handshake to IE_out_valid.
- IE_in_ready = !IE_out_valid | IE_out_ready, combinational from state and IE_out_ready.
- Full throughput: one word per cycle when IE_out_ready is held high.
- Holding rule: while IE_out_valid & !IE_out_ready, IE_instr, IE_err, IE_err_code and IE_addr stay stable, and IE_in_ready=0.
- IE_out_valid never drops without a handshake.
- Reset values:
  - IE_out_valid=0, IE_instr=0, IE_err=0, IE_err_code=0
  - IE_addr=ADDR_BASE, both counters=0
  - IE_in_ready=1
- Reset mid-transfer drops any held word silently.
- IE_addr is registered: it equals the address of the word currently presented and updates on the cycle after the handshake.

## Structure
- Package otter_enc_pkg holds:
  - fmt enum (R..J values above)
  - err_code enum
  - NOP constant 32'h0000_0013
  - range-limit localparams
- Sub-module imm_pack is purely combinational: fields + imm in, word + err_code out.
- The top level owns the handshake register, address and counters.

## Test plan
- I, opcode 0010011, rd=1, rs1=0, funct3=0, imm=-1 -> IE_instr=0xFFF00093, err=0, addr=ADDR_BASE, one cycle after accept.
- B, opcode 1100011, rs1=rs2=0, imm=-4 -> 0xFE000EE3. J, opcode 1101111, rd=1, imm=8 -> 0x008000EF. U, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7. Addr steps by 4 across the stream.
- Errors:
  - I with imm=2048 -> 0x00000013, err_code=1.
  - B with imm=5 -> err_code=2.
  - fmt=6 -> err_code=3.
  - Result: IE_err_cnt=3, IE_word_cnt=3.
- Backpressure: three back-to-back requests with IE_out_ready low for 3 cycles -> first word held stable, IE_in_ready=0, no loss or duplication; after release all three emerge in order at consecutive addresses.
- IE_clr asserted in the same cycle as a handshake -> addr=ADDR_BASE and counters=0 next cycle; the held word is unaffected. Counters saturate at 0xFFFF (CNT_W=16) under forced long streams.
- Round trip: random legal immediates per format, decoded back through the core's immediate generator -> equals the original IE_imm.
